// File: rtl/l1_mem_arbiter.sv
// Shares one memory port between the L1 icache and dcache; refills are issued as bursts
// and reassembled into a full line. Define ARB_RR_EN for round-robin tie-breaking.
module l1_mem_arbiter #(
    parameter int offset_width = 2
) (
    input  logic                               clk,
    input  logic                               rstn,

    input  logic                               icache_mem_req,
    input  logic [31:0]                        icache_mem_addr,
    input  logic                               icache_mem_SUC,
    output logic                               mem_icache_addrOK,
    output logic                               mem_icache_dataOK,
    output logic [32*(1<<offset_width)-1:0]    mem_icache_data,

    input  logic                               dcache_mem_req,
    input  logic                               dcache_mem_wr,
    input  logic                               dcache_mem_SUC,
    input  logic [31:0]                        dcache_mem_addr,
    input  logic [31:0]                        dcache_mem_dout,
    input  logic [1:0]                         dcache_mem_size,
    input  logic [3:0]                         dcache_mem_wstrb,
    output logic                               mem_dcache_addrOK,
    output logic                               mem_dcache_dataOK,
    output logic [32*(1<<offset_width)-1:0]    mem_dcache_data,

    output logic                               arb_mem_req,
    output logic                               arb_mem_wr,
    output logic [31:0]                        arb_mem_addr,
    output logic [31:0]                        arb_mem_wdata,
    output logic [1:0]                         arb_mem_size,
    output logic [3:0]                         arb_mem_wstrb,
    output logic [7:0]                         arb_mem_len,
    input  logic                               mem_arb_addrOK,
    input  logic                               mem_arb_dataOK,
    input  logic [31:0]                        mem_arb_rdata
);

    localparam int N    = 1 << offset_width;
    localparam int LINE = 32 * N;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_reg;
    logic        owner_reg;
    logic        wr_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic [3:0]  wstrb_reg;
    logic [7:0]  len_reg;
    logic [7:0]  beat_cnt_reg;

    logic        grant_valid;
    logic        grant_dcache;
    logic        wr_next;
    logic [31:0] addr_next;
    logic [31:0] wdata_next;
    logic [1:0]  size_next;
    logic [3:0]  wstrb_next;
    logic [7:0]  len_next;
    logic        beat_we;
    logic [LINE-1:0] line_flat;

    assign grant_valid = icache_mem_req | dcache_mem_req;

`ifdef ARB_RR_EN
    logic last_grant_reg;
    // On a tie, whoever did not win last time goes first.
    assign grant_dcache = dcache_mem_req & (~icache_mem_req | ~last_grant_reg);
`else
    assign grant_dcache = dcache_mem_req;
`endif

    // Downstream request fields for whichever requester wins this cycle.
    always_comb begin
        wr_next    = 1'b0;
        addr_next  = icache_mem_addr;
        wdata_next = 32'd0;
        size_next  = 2'd2;
        wstrb_next = 4'd0;
        len_next   = icache_mem_SUC ? 8'd0 : 8'(N - 1);
        if (grant_dcache) begin
            addr_next = dcache_mem_addr;
            if (dcache_mem_wr) begin
                wr_next    = 1'b1;
                wdata_next = dcache_mem_dout;
                size_next  = dcache_mem_size;
                wstrb_next = dcache_mem_wstrb;
                len_next   = 8'd0;
            end else if (dcache_mem_SUC) begin
                size_next  = dcache_mem_size;
                wstrb_next = dcache_mem_wstrb;
                len_next   = 8'd0;
            end else begin
                len_next   = 8'(N - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            wr_reg       <= 1'b0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            size_reg     <= 2'd0;
            wstrb_reg    <= 4'd0;
            len_reg      <= 8'd0;
            beat_cnt_reg <= 8'd0;
`ifdef ARB_RR_EN
            last_grant_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        owner_reg <= grant_dcache;
                        wr_reg    <= wr_next;
                        addr_reg  <= addr_next;
                        wdata_reg <= wdata_next;
                        size_reg  <= size_next;
                        wstrb_reg <= wstrb_next;
                        len_reg   <= len_next;
`ifdef ARB_RR_EN
                        last_grant_reg <= grant_dcache;
`endif
                        state_reg <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_arb_addrOK) begin
                        beat_cnt_reg <= 8'd0;
                        state_reg    <= DATA;
                    end
                end
                DATA: begin
                    if (mem_arb_dataOK) begin
                        if (wr_reg) begin
                            state_reg <= DONE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 8'd1;
                            if (beat_cnt_reg == len_reg)
                                state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign beat_we = (state_reg == DATA) && mem_arb_dataOK && !wr_reg;

    // The first beat of a read also clears the rest of the line, so an uncached
    // word comes back zero-extended and the previous line stays visible until then.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    word_reg <= 32'd0;
                end else if (beat_we) begin
                    if (beat_cnt_reg == 8'd0)
                        word_reg <= (gi == 0) ? mem_arb_rdata : 32'd0;
                    else if (beat_cnt_reg == 8'(gi))
                        word_reg <= mem_arb_rdata;
                end
            end
            assign line_flat[gi*32 +: 32] = word_reg;
        end
    endgenerate

    assign arb_mem_req   = (state_reg == ADDR);
    assign arb_mem_wr    = arb_mem_req ? wr_reg    : 1'b0;
    assign arb_mem_addr  = arb_mem_req ? addr_reg  : 32'd0;
    assign arb_mem_wdata = arb_mem_req ? wdata_reg : 32'd0;
    assign arb_mem_size  = arb_mem_req ? size_reg  : 2'd0;
    assign arb_mem_wstrb = arb_mem_req ? wstrb_reg : 4'd0;
    assign arb_mem_len   = arb_mem_req ? len_reg   : 8'd0;

    assign mem_icache_addrOK = (state_reg == ADDR) && mem_arb_addrOK && !owner_reg;
    assign mem_dcache_addrOK = (state_reg == ADDR) && mem_arb_addrOK &&  owner_reg;
    assign mem_icache_dataOK = (state_reg == DONE) && !owner_reg;
    assign mem_dcache_dataOK = (state_reg == DONE) &&  owner_reg;

    assign mem_icache_data = line_flat;
    assign mem_dcache_data = line_flat;

endmodule
